ram_req_arbiter: RTL and testbench

- Two-master, round-robin request/grant arbiter that sits directly upstream of the single-port RAM wrapper.
- Master 0 is the instruction fetch port and master 1 is the core data port.
- Converts each master's req/gnt/rvalid protocol into the RAM's en/addr/we/be/wdata controls.
- Tracks the 1-cycle RAM read latency so each response is routed back to the master that issued it.
- Out-of-window accesses are granted but never reach the RAM; they return an error response instead.

---
 rtl/ram_req_arbiter.sv | 107 ++++++++++
 tb/tb_ram_req_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ram_req_arbiter.sv
// Two-master round-robin arbiter in front of a single-port RAM with 1-cycle read latency.
// Out-of-window accesses are granted, kept off the RAM and answered with an error response.
module ram_req_arbiter #(
  parameter int          RAM_SIZE   = 32768,
  parameter int          ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter logic [31:0] BASE_ADDR  = 32'h0010_0000
) (
  input  logic                  clk,
  input  logic                  rstn_i,
  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  input  logic [31:0]           m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [31:0]           m0_wdata_i,
  output logic                  m0_rvalid_o,
  output logic [31:0]           m0_rdata_o,
  output logic                  m0_err_o,
  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  input  logic [31:0]           m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [31:0]           m1_wdata_i,
  output logic                  m1_rvalid_o,
  output logic [31:0]           m1_rdata_o,
  output logic                  m1_err_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  logic        w_grant;
  logic        w_winner;
  logic        w_in_range;
  logic [31:0] w_addr;
  logic        w_we;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  logic        r_rr;
  logic        r_resp_valid;
  logic        r_resp_port;
  logic        r_resp_err;

  // Winner select; the request fields are forced to zero when idle so the RAM side is quiet.
  always_comb begin
    w_grant  = m0_req_i | m1_req_i;
    w_winner = (m0_req_i && m1_req_i) ? r_rr : m1_req_i;
    w_addr   = 32'h0;
    w_we     = 1'b0;
    w_be     = 4'h0;
    w_wdata  = 32'h0;
    if (w_grant) begin
      if (w_winner) begin
        w_addr  = m1_addr_i;
        w_we    = m1_we_i;
        w_be    = m1_be_i;
        w_wdata = m1_wdata_i;
      end else begin
        w_addr  = m0_addr_i;
        w_we    = m0_we_i;
        w_be    = m0_be_i;
        w_wdata = m0_wdata_i;
      end
    end
  end

  assign w_in_range = (w_addr[31:ADDR_WIDTH] == BASE_ADDR[31:ADDR_WIDTH]);

  assign m0_gnt_o    = w_grant & ~w_winner;
  assign m1_gnt_o    = w_grant &  w_winner;

  assign ram_en_o    = w_grant & w_in_range;
  assign ram_addr_o  = w_addr[ADDR_WIDTH-1:0];
  assign ram_we_o    = w_we & ram_en_o;
  assign ram_be_o    = w_be;
  assign ram_wdata_o = w_wdata;

  // Response stage: remembers who was granted so the RAM data one cycle later is routed back.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rr         <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_port  <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      if (w_grant) begin
        r_rr <= ~w_winner;
      end
      r_resp_valid <= w_grant;
      r_resp_port  <= w_winner;
      r_resp_err   <= w_grant & ~w_in_range;
    end
  end

  assign m0_rvalid_o = r_resp_valid & (r_resp_port == 1'b0);
  assign m1_rvalid_o = r_resp_valid & (r_resp_port == 1'b1);
  assign m0_err_o    = m0_rvalid_o & r_resp_err;
  assign m1_err_o    = m1_rvalid_o & r_resp_err;
  assign m0_rdata_o  = (m0_rvalid_o & ~r_resp_err) ? ram_rdata_i : 32'h0;
  assign m1_rdata_o  = (m1_rvalid_o & ~r_resp_err) ? ram_rdata_i : 32'h0;

endmodule

// File: tb/tb_ram_req_arbiter.sv
// Bench for ram_req_arbiter: directed requests, expected responses queued and checked by a monitor.
`timescale 1ns/1ps
module tb_ram_req_arbiter;

  localparam int AW = 15;

  logic        clk = 1'b0;
  logic        rstn_i;
  logic        m0_req_i, m1_req_i, m0_gnt_o, m1_gnt_o;
  logic [31:0] m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
  logic        m0_we_i, m1_we_i;
  logic [3:0]  m0_be_i, m1_be_i;
  logic        m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        ram_en_o, ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        port;
    logic        err;
    logic        chk;
    logic [31:0] rd;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mem [0:8191];

  always #5 clk = ~clk;

  ram_req_arbiter dut (
    .clk(clk), .rstn_i(rstn_i),
    .m0_req_i(m0_req_i), .m0_gnt_o(m0_gnt_o), .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i),
    .m0_be_i(m0_be_i), .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o),
    .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_gnt_o(m1_gnt_o), .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i),
    .m1_be_i(m1_be_i), .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o),
    .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .ram_en_o(ram_en_o), .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  // Behavioural single-port RAM with one cycle of read latency
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (ram_be_o[b]) mem[ram_addr_o[AW-1:2]][8*b +: 8] <= ram_wdata_o[8*b +: 8];
      end else begin
        ram_rdata_i <= mem[ram_addr_o[AW-1:2]];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_port(input logic port, input logic err, input logic [31:0] rd);
    exp_t e;
    if (exp_q.size() == 0) begin
      check(port ? "m1_unexpected_rvalid" : "m0_unexpected_rvalid", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("resp_port", {31'd0, port}, {31'd0, e.port});
      check("resp_err", {31'd0, err}, {31'd0, e.err});
      if (e.chk) check("resp_rdata", rd, e.rd);
    end
  endtask

  // Monitor: pops one expectation per response seen
  always @(negedge clk) begin
    if (rstn_i === 1'b1) begin
      if (m0_rvalid_o && m1_rvalid_o) check("dual_rvalid", 32'd1, 32'd0);
      if (m0_rvalid_o) mon_port(1'b0, m0_err_o, m0_rdata_o);
      if (m1_rvalid_o) mon_port(1'b1, m1_err_o, m1_rdata_o);
    end
  end

  task automatic clear_reqs();
    m0_req_i = 0; m1_req_i = 0; m0_we_i = 0; m1_we_i = 0;
    m0_be_i = 0; m1_be_i = 0; m0_addr_i = 0; m1_addr_i = 0; m0_wdata_i = 0; m1_wdata_i = 0;
  endtask

  task automatic set_req(input logic p, input logic [31:0] a, input logic we,
                         input logic [3:0] be, input logic [31:0] wd);
    if (p) begin
      m1_req_i = 1; m1_addr_i = a; m1_we_i = we; m1_be_i = be; m1_wdata_i = wd;
    end else begin
      m0_req_i = 1; m0_addr_i = a; m0_we_i = we; m0_be_i = be; m0_wdata_i = wd;
    end
  endtask

  // One lone-master transaction: same-cycle grant/RAM drive, response one cycle later
  task automatic single(input logic p, input logic [31:0] a, input logic we, input logic [3:0] be,
                        input logic [31:0] wd, input logic exp_err, input logic chk_rd,
                        input logic [31:0] exp_rd);
    exp_t e;
    @(posedge clk); #1;
    set_req(p, a, we, be, wd);
    @(negedge clk);
    check("gnt_winner", {31'd0, p ? m1_gnt_o : m0_gnt_o}, 32'd1);
    check("gnt_loser", {31'd0, p ? m0_gnt_o : m1_gnt_o}, 32'd0);
    check("ram_en", {31'd0, ram_en_o}, {31'd0, ~exp_err});
    check("ram_we", {31'd0, ram_we_o}, {31'd0, we & ~exp_err});
    if (!exp_err) begin
      check("ram_addr", {17'd0, ram_addr_o}, {17'd0, a[AW-1:0]});
      check("ram_be", {28'd0, ram_be_o}, {28'd0, be});
      if (we) check("ram_wdata", ram_wdata_o, wd);
    end
    e.port = p; e.err = exp_err; e.chk = chk_rd; e.rd = exp_rd;
    exp_q.push_back(e);
    @(posedge clk); #1;
    clear_reqs();
    @(negedge clk);
    check("rvalid_latency", {31'd0, p ? m1_rvalid_o : m0_rvalid_o}, 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    rstn_i = 0;
    repeat (cycles) @(posedge clk);
    #1 rstn_i = 1;
  endtask

  initial begin
    exp_t e;
    for (int i = 0; i < 8192; i++) mem[i] = 32'h0;
    ram_rdata_i = 32'h0;
    clear_reqs();

    // Reset then idle
    do_reset(3);
    @(negedge clk);
    check("idle_m0_gnt", {31'd0, m0_gnt_o}, 32'd0);
    check("idle_m1_gnt", {31'd0, m1_gnt_o}, 32'd0);
    check("idle_rvalid", {30'd0, m1_rvalid_o, m0_rvalid_o}, 32'd0);
    check("idle_err", {30'd0, m1_err_o, m0_err_o}, 32'd0);
    check("idle_ram_en", {31'd0, ram_en_o}, 32'd0);
    check("idle_ram_we", {31'd0, ram_we_o}, 32'd0);

    // Single master write then read back
    single(1'b1, 32'h0010_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    single(1'b1, 32'h0010_0010, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF);
    single(1'b0, 32'h0010_0020, 1'b1, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);

    // Out-of-window read and write; the write aliases 0x10 and must not land
    single(1'b0, 32'h0000_0100, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 32'h0);
    single(1'b0, 32'h0000_0010, 1'b1, 4'hF, 32'h5555_5555, 1'b1, 1'b1, 32'h0);
    single(1'b1, 32'h0010_0010, 1'b0, 4'hF, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF);

    // Byte enables
    single(1'b0, 32'h0010_0030, 1'b1, 4'hF,    32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0);
    single(1'b0, 32'h0010_0030, 1'b1, 4'b0101, 32'h1122_3344, 1'b0, 1'b0, 32'h0);
    single(1'b1, 32'h0010_0030, 1'b0, 4'hF,    32'h0,         1'b0, 1'b1, 32'hFF22_FF44);

    // Contention from reset: strict alternation m0, m1, m0, m1
    @(posedge clk); #1;
    rstn_i = 0;
    set_req(1'b0, 32'h0010_0010, 1'b0, 4'hF, 32'h0);
    set_req(1'b1, 32'h0010_0020, 1'b0, 4'hF, 32'h0);
    repeat (2) @(posedge clk);
    #1 rstn_i = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("cont_m0_gnt", {31'd0, m0_gnt_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("cont_m1_gnt", {31'd0, m1_gnt_o}, (i % 2 == 1) ? 32'd1 : 32'd0);
      e.port = (i % 2 == 1); e.err = 1'b0; e.chk = 1'b1;
      e.rd = (i % 2 == 1) ? 32'hCAFE_F00D : 32'hDEAD_BEEF;
      exp_q.push_back(e);
      @(posedge clk);
    end
    #1 clear_reqs();
    repeat (2) @(posedge clk);

    // Reset right after an m0 read grant drops the response
    #1 set_req(1'b0, 32'h0010_0010, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    check("rst_mid_gnt", {31'd0, m0_gnt_o}, 32'd1);
    rstn_i = 0;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1 rstn_i = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mid_no_rvalid", {31'd0, m0_rvalid_o}, 32'd0);
    end
    @(posedge clk); #1;
    set_req(1'b0, 32'h0010_0010, 1'b0, 4'hF, 32'h0);
    set_req(1'b1, 32'h0010_0020, 1'b0, 4'hF, 32'h0);
    @(negedge clk);
    check("post_rst_m0_gnt", {31'd0, m0_gnt_o}, 32'd1);
    check("post_rst_m1_gnt", {31'd0, m1_gnt_o}, 32'd0);
    e.port = 1'b0; e.err = 1'b0; e.chk = 1'b1; e.rd = 32'hDEAD_BEEF;
    exp_q.push_back(e);
    @(posedge clk); #1;
    clear_reqs();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pending_responses", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
